fir_result_reader: RTL

Output-side drain for `fir_filter_core`. It watches the core's `empty` flag, pops one filtered result at a time with a single-cycle `read` pulse, and captures the 32-bit signed `sum` after a fixed read latency. Each result is rounded, scaled and saturated to a 16-bit sample, then offered downstream on a valid/ready handshake. It sits between the filter core and the DAC or host sample sink, in the `clk3` domain.

---
 rtl/fir_result_reader_if.sv | 45 ++++
 rtl/fir_result_reader.sv | 117 +++++++++++
 2 files changed

// File: rtl/fir_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_result_reader_if
// Description : Core-side pop bus and downstream sample handshake for
//               fir_result_reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_result_reader_if #(
    parameter int SUM_W = 32,
    parameter int OUT_W = 16
);
    logic             empty;
    logic [SUM_W-1:0] sum;
    logic             read;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sat_flag;
    logic [15:0]      count;

    // Environment side: filter core plus downstream sink
    modport master (
        output empty,
        output sum,
        output out_ready,
        input  read,
        input  out_data,
        input  out_valid,
        input  sat_flag,
        input  count
    );

    // Reader side
    modport slave (
        input  empty,
        input  sum,
        input  out_ready,
        output read,
        output out_data,
        output out_valid,
        output sat_flag,
        output count
    );
endinterface
`default_nettype wire

// File: rtl/fir_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : fir_result_reader
// Description : Drains fir_filter_core results one at a time, rounds, scales
//               and saturates each to OUT_W bits, offers it on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_result_reader #(
    parameter int SUM_W    = 32,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 8,
    parameter int READ_LAT = 1
) (
    input  wire logic          clk3,
    input  wire logic          reset,
    fir_result_reader_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] c_wait_init = 2'(READ_LAT - 1);
    localparam logic signed [SUM_W:0] c_round =
        $signed({{SUM_W{1'b0}}, 1'b1} << (SHIFT - 1));
    localparam logic signed [SUM_W:0] c_out_max =
        $signed({{(SUM_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [SUM_W:0] c_out_min =
        $signed({{(SUM_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}});

    state_t             r_state;
    logic [1:0]         r_wait_cnt;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_sat_flag;
    logic [15:0]        r_count;

    logic signed [SUM_W:0] w_sum_ext;
    logic signed [SUM_W:0] w_rounded;
    logic signed [SUM_W:0] w_shifted;
    logic                  w_sat_hi;
    logic                  w_sat_lo;
    logic [OUT_W-1:0]      w_scaled;

    // One guard bit keeps the rounding add from overflowing near full scale
    always_comb begin
        w_sum_ext = $signed({bus.sum[SUM_W-1], bus.sum});
        w_rounded = w_sum_ext + c_round;
        w_shifted = w_rounded >>> SHIFT;
        w_sat_hi  = (w_shifted > c_out_max);
        w_sat_lo  = (w_shifted < c_out_min);
        if (w_sat_hi) begin
            w_scaled = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (w_sat_lo) begin
            w_scaled = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            w_scaled = w_shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk3) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 2'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.empty) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_wait_cnt <= c_wait_init;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_out_data  <= w_scaled;
                        r_out_valid <= 1'b1;
                        if (w_sat_hi || w_sat_lo) begin
                            r_sat_flag <= 1'b1;
                        end
                        r_state <= S_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_HOLD: begin
                    // Skipping IDLE here gives one result per READ_LAT+2 cycles
                    if (bus.out_ready) begin
                        r_count     <= r_count + 16'd1;
                        r_out_valid <= 1'b0;
                        r_state     <= bus.empty ? S_IDLE : S_READ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.read      = (r_state == S_READ);
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.sat_flag  = r_sat_flag;
    assign bus.count     = r_count;

endmodule
`default_nettype wire
